// File: rtl/alu_cmd_issuer.sv
// Command issuer for a 4-bit combinational ALU: registers operands/select, captures
// the result one cycle later into an in-order FIFO. Optional flags: `ALU_FLAGS_EN.
module alu_cmd_issuer #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [3:0] cmd_a,
    input  logic [3:0] cmd_b,
    input  logic [2:0] cmd_op,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic [2:0] alu_sel,
    input  logic [3:0] alu_y,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [3:0] rsp_y,
    output logic [2:0] rsp_op,
    output logic       rsp_err
`ifdef ALU_FLAGS_EN
   ,output logic       rsp_z,
    output logic       rsp_c
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_XOR = 3'b100;

    typedef enum logic {IDLE, ISSUE} state_t;

    state_t           state_q, state_d;
    logic [3:0]       a_q, a_d, b_q, b_d;
    logic [2:0]       sel_q, sel_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             push, pop, accept, err_now;

    logic [3:0]       mem_y   [DEPTH];
    logic [2:0]       mem_op  [DEPTH];
    logic             mem_err [DEPTH];
`ifdef ALU_FLAGS_EN
    logic             mem_z   [DEPTH];
    logic             mem_c   [DEPTH];
    logic [4:0]       sum_ext;
    logic             z_now, c_now;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            sel_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sel_q    <= sel_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Issue FSM: accept in IDLE, push the settled ALU result as ISSUE ends.
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        sel_d     = sel_q;
        cmd_ready = 1'b0;
        accept    = 1'b0;
        push      = 1'b0;
        case (state_q)
            IDLE: begin
                cmd_ready = !rst && (cnt_q < DEPTH_C);
                accept    = cmd_valid && !rst && (cnt_q < DEPTH_C);
                if (accept) begin
                    a_d     = cmd_a;
                    b_d     = cmd_b;
                    sel_d   = cmd_op;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                push    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign rsp_valid = (cnt_q != '0);
    assign pop       = rsp_valid && rsp_ready;
    assign err_now   = (sel_q > OP_XOR);

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

`ifdef ALU_FLAGS_EN
    always_comb begin
        sum_ext = {1'b0, a_q} + {1'b0, b_q};
        z_now   = (alu_y == 4'h0);
        c_now   = 1'b0;
        if (sel_q == OP_ADD)
            c_now = sum_ext[4];
        else if (sel_q == OP_SUB)
            c_now = (a_q < b_q);
    end
`endif

    // Result storage carries no reset; validity is tracked by the pointers/count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_y[wr_ptr_q]   <= alu_y;
            mem_op[wr_ptr_q]  <= sel_q;
            mem_err[wr_ptr_q] <= err_now;
`ifdef ALU_FLAGS_EN
            mem_z[wr_ptr_q]   <= z_now;
            mem_c[wr_ptr_q]   <= c_now;
`endif
        end
    end

    assign alu_a   = a_q;
    assign alu_b   = b_q;
    assign alu_sel = sel_q;
    assign rsp_y   = rsp_valid ? mem_y[rd_ptr_q]   : 4'h0;
    assign rsp_op  = rsp_valid ? mem_op[rd_ptr_q]  : 3'b000;
    assign rsp_err = rsp_valid ? mem_err[rd_ptr_q] : 1'b0;
`ifdef ALU_FLAGS_EN
    assign rsp_z   = rsp_valid ? mem_z[rd_ptr_q]   : 1'b0;
    assign rsp_c   = rsp_valid ? mem_c[rd_ptr_q]   : 1'b0;
`endif

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Directed bench for alu_cmd_issuer with a behavioural 4-bit ALU attached.
module tb_alu_cmd_issuer;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid, cmd_ready;
    logic [3:0] cmd_a, cmd_b;
    logic [2:0] cmd_op;
    logic [3:0] alu_a, alu_b, alu_y;
    logic [2:0] alu_sel;
    logic       rsp_valid, rsp_ready;
    logic [3:0] rsp_y;
    logic [2:0] rsp_op;
    logic       rsp_err;
`ifdef ALU_FLAGS_EN
    logic       rsp_z, rsp_c;
`endif

    int n_asrt = 0;
    int n_fail = 0;

    alu_cmd_issuer #(.DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_y(alu_y),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_y(rsp_y), .rsp_op(rsp_op), .rsp_err(rsp_err)
`ifdef ALU_FLAGS_EN
       ,.rsp_z(rsp_z), .rsp_c(rsp_c)
`endif
    );

    always #5 clk = ~clk;

    always_comb begin
        case (alu_sel)
            3'b000:  alu_y = alu_a + alu_b;
            3'b001:  alu_y = alu_a - alu_b;
            3'b010:  alu_y = alu_a & alu_b;
            3'b011:  alu_y = alu_a | alu_b;
            3'b100:  alu_y = alu_a ^ alu_b;
            default: alu_y = 4'h0;
        endcase
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input string tag, input logic [3:0] a, input logic [3:0] b,
                        input logic [2:0] op);
        logic got;
        got       = 1'b0;
        cmd_a     = a;
        cmd_b     = b;
        cmd_op    = op;
        cmd_valid = 1'b1;
        for (int i = 0; i < 20 && !got; i++) begin
            got = cmd_ready;
            step();
        end
        cmd_valid = 1'b0;
        chk({tag, "_acc"}, 8'(got), 8'd1);
    endtask

    task automatic recv(input string tag, input logic [3:0] y, input logic [2:0] op,
                        input logic err, input logic z, input logic c);
        logic seen;
        seen      = 1'b0;
        rsp_ready = 1'b1;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (rsp_valid) seen = 1'b1;
            else step();
        end
        chk({tag, "_vld"}, 8'(seen), 8'd1);
        chk({tag, "_y"},   8'(rsp_y), 8'(y));
        chk({tag, "_op"},  8'(rsp_op), 8'(op));
        chk({tag, "_err"}, 8'(rsp_err), 8'(err));
`ifdef ALU_FLAGS_EN
        chk({tag, "_z"},   8'(rsp_z), 8'(z));
        chk({tag, "_c"},   8'(rsp_c), 8'(c));
`else
        if (z === 1'bx || c === 1'bx) $display("note: %s flag args unknown", tag);
`endif
        step();
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_op = '0; rsp_ready = 1'b0;
        step();
        step();
        chk("rst_cmd_ready", 8'(cmd_ready), 8'd0);
        chk("rst_rsp_valid", 8'(rsp_valid), 8'd0);
        chk("rst_alu_a",     8'(alu_a),     8'd0);
        chk("rst_alu_b",     8'(alu_b),     8'd0);
        chk("rst_alu_sel",   8'(alu_sel),   8'd0);
        chk("rst_rsp_y",     8'(rsp_y),     8'd0);
        chk("rst_rsp_err",   8'(rsp_err),   8'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_ready", 8'(cmd_ready), 8'd1);
        rsp_ready = 1'b1;
        step();
        chk("pop_empty_vld", 8'(rsp_valid), 8'd0);

        // 1: ADD 9+8 wraps to 1 with carry
        send("t1", 4'h9, 4'h8, 3'b000);
        chk("t1_alu_a",   8'(alu_a),     8'h9);
        chk("t1_alu_b",   8'(alu_b),     8'h8);
        chk("t1_issue_rdy", 8'(cmd_ready), 8'd0);
        recv("t1", 4'h1, 3'b000, 1'b0, 1'b0, 1'b1);

        // 2: subtraction with borrow, then exact zero
        send("t2a", 4'h3, 4'h5, 3'b001);
        recv("t2a", 4'hE, 3'b001, 1'b0, 1'b0, 1'b1);
        send("t2b", 4'h5, 4'h5, 3'b001);
        recv("t2b", 4'h0, 3'b001, 1'b0, 1'b1, 1'b0);

        // 3: illegal op then XOR
        send("t3a", 4'hF, 4'hF, 3'b110);
        chk("t3a_alu_sel", 8'(alu_sel), 8'h6);
        recv("t3a", 4'h0, 3'b110, 1'b1, 1'b1, 1'b0);
        send("t3b", 4'hA, 4'h5, 3'b100);
        recv("t3b", 4'hF, 3'b100, 1'b0, 1'b0, 1'b0);

        // 4: fill FIFO with consumer stalled
        rsp_ready = 1'b0;
        send("t4_0", 4'h1, 4'h2, 3'b000);
        send("t4_1", 4'hC, 4'h3, 3'b011);
        send("t4_2", 4'h6, 4'h3, 3'b010);
        send("t4_3", 4'h2, 4'h1, 3'b001);
        step();
        chk("t4_full_rdy", 8'(cmd_ready), 8'd0);
        chk("t4_full_vld", 8'(rsp_valid), 8'd1);
        cmd_a = 4'h7; cmd_b = 4'h7; cmd_op = 3'b000; cmd_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t4_hold_rdy",  8'(cmd_ready), 8'd0);
            chk("t4_hold_y",    8'(rsp_y),     8'h3);
            chk("t4_hold_alua", 8'(alu_a),     8'h2);
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk("t4_reopen_rdy", 8'(cmd_ready), 8'd1);
        chk("t4_head_y",     8'(rsp_y),     8'hF);
        step();
        cmd_valid = 1'b0;
        chk("t4_5th_alua",  8'(alu_a),   8'h7);
        chk("t4_5th_sel",   8'(alu_sel), 8'h0);
        recv("t4_r1", 4'hF, 3'b011, 1'b0, 1'b0, 1'b0);
        recv("t4_r2", 4'h2, 3'b010, 1'b0, 1'b0, 1'b0);
        recv("t4_r3", 4'h1, 3'b001, 1'b0, 1'b0, 1'b0);
        recv("t4_r4", 4'hE, 3'b000, 1'b0, 1'b0, 1'b0);
        chk("t4_empty", 8'(rsp_valid), 8'd0);

        // 5: streaming, valid held high
        rsp_ready = 1'b1;
        cmd_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cmd_a = 4'(k + 1); cmd_b = 4'h1; cmd_op = 3'b000;
            chk("t5_idle_rdy", 8'(cmd_ready), 8'd1);
            if (k > 0) begin
                chk("t5_vld", 8'(rsp_valid), 8'd1);
                chk("t5_y",   8'(rsp_y),     8'(k + 1));
            end
            step();
            chk("t5_issue_rdy", 8'(cmd_ready), 8'd0);
            chk("t5_issue_vld", 8'(rsp_valid), 8'd0);
            step();
        end
        cmd_valid = 1'b0;
        chk("t5_last_vld", 8'(rsp_valid), 8'd1);
        chk("t5_last_y",   8'(rsp_y),     8'h5);
        step();
        chk("t5_drained", 8'(rsp_valid), 8'd0);

        // 6: reset during ISSUE with one result buffered
        rsp_ready = 1'b0;
        send("t6a", 4'hF, 4'hF, 3'b010);
        step();
        chk("t6_buffered", 8'(rsp_valid), 8'd1);
        send("t6b", 4'h3, 4'h4, 3'b000);
        chk("t6_alu_a", 8'(alu_a), 8'h3);
        #1;
        rst = 1'b1;
        #1;
        chk("t6_rst_vld",   8'(rsp_valid), 8'd0);
        chk("t6_rst_alua",  8'(alu_a),     8'd0);
        chk("t6_rst_alub",  8'(alu_b),     8'd0);
        chk("t6_rst_sel",   8'(alu_sel),   8'd0);
        chk("t6_rst_rdy",   8'(cmd_ready), 8'd0);
        chk("t6_rst_y",     8'(rsp_y),     8'd0);
        step();
        rst = 1'b0;
        rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("t6_no_result", 8'(rsp_valid), 8'd0);
            step();
        end
        chk("t6_ready_again", 8'(cmd_ready), 8'd1);
        send("t6c", 4'hF, 4'h1, 3'b000);
        recv("t6c", 4'h0, 3'b000, 1'b0, 1'b1, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
